// File: rtl/mips_pkg.sv
// Shared MIPS core constants: register width, FP register file shape, WB arbitration defaults.
// Pure declarations; no logic, no latency, no backpressure.
package mips_pkg;

    localparam int REG_LEN              = 32;
    localparam int FP_REG_COUNT         = 32;
    localparam int REG_ADDR_W           = 5;
    localparam int STARVE_LIMIT_DEFAULT = 4;
    localparam int AGE_W                = 3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [AGE_W-1:0]      age_t;

endpackage

// File: rtl/wb_fp_fifo.sv
// Pending FPU-result queue (destination + data); head visible the cycle after push, pop frees on the edge.
// Pushes while full and pops while empty are dropped; the caller gates them with full/empty.
module wb_fp_fifo
    import mips_pkg::*;
#(
    parameter int REG_LEN    = mips_pkg::REG_LEN,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  reg_addr_t          push_fd,
    input  logic [REG_LEN-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output reg_addr_t          head_fd,
    output logic [REG_LEN-1:0] head_data
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        reg_addr_t          fd;
        logic [REG_LEN-1:0] data;
    } entry_t;

    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    // Pointers wrap at FIFO_DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= '{fd: push_fd, data: push_data};
    end

    assign head_fd   = mem[rd_ptr].fd;
    assign head_data = mem[rd_ptr].data;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the FP register-file write port between the pipeline and queued FPU results; integer port passes through.
// Outputs registered (1 cycle); fpu_ready = queue not full; a starved queue head forces a one-cycle pipe_stall.
module wb_port_arbiter
    import mips_pkg::*;
#(
    parameter int REG_LEN      = mips_pkg::REG_LEN,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = mips_pkg::STARVE_LIMIT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_int_we,
    input  reg_addr_t               wb_int_rd,
    input  logic [REG_LEN-1:0]      wb_int_data,
    input  logic                    wb_fp_we,
    input  reg_addr_t               wb_fp_fd,
    input  logic [REG_LEN-1:0]      wb_fp_data,
    input  logic                    fpu_issue,
    input  reg_addr_t               fpu_issue_fd,
    input  logic                    fpu_valid,
    input  reg_addr_t               fpu_fd,
    input  logic [REG_LEN-1:0]      fpu_data,
    output logic                    fpu_ready,
    output logic                    rf_we,
    output reg_addr_t               rf_waddr,
    output logic [REG_LEN-1:0]      rf_wdata,
    output logic                    frf_we,
    output reg_addr_t               frf_waddr,
    output logic [REG_LEN-1:0]      frf_wdata,
    output logic                    pipe_stall,
    output logic [FP_REG_COUNT-1:0] fp_busy
);

    localparam age_t STALL_AGE = age_t'(STARVE_LIMIT);

    logic                    full;
    logic                    empty;
    reg_addr_t               head_fd;
    logic [REG_LEN-1:0]      head_data;
    logic                    push;
    logic                    grant_fifo;
    logic                    grant_pipe;
    age_t                    age;
    age_t                    age_next;
    logic [FP_REG_COUNT-1:0] fp_busy_next;

    assign fpu_ready = !full;
    assign push      = fpu_valid && !full;

    wb_fp_fifo #(
        .REG_LEN    (REG_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_fd   (fpu_fd),
        .push_data (fpu_data),
        .pop       (grant_fifo),
        .full      (full),
        .empty     (empty),
        .head_fd   (head_fd),
        .head_data (head_data)
    );

    // A stall cycle belongs to the queue head; the pipeline request is ignored and re-presented.
    always_comb begin
        grant_pipe = !pipe_stall && wb_fp_we;
        grant_fifo = !empty && (pipe_stall || !wb_fp_we);

        age_next = age;
        if (empty || grant_fifo) age_next = '0;
        else                     age_next = age + 1'b1;

        fp_busy_next = fp_busy;
        if (grant_fifo) fp_busy_next[head_fd]      = 1'b0;
        if (fpu_issue)  fp_busy_next[fpu_issue_fd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            frf_we     <= 1'b0;
            frf_waddr  <= '0;
            frf_wdata  <= '0;
            pipe_stall <= 1'b0;
            fp_busy    <= '0;
            age        <= '0;
        end else begin
            rf_we    <= wb_int_we;
            rf_waddr <= wb_int_rd;
            rf_wdata <= wb_int_data;

            frf_we <= grant_pipe || grant_fifo;
            if (grant_fifo) begin
                frf_waddr <= head_fd;
                frf_wdata <= head_data;
            end else begin
                frf_waddr <= wb_fp_fd;
                frf_wdata <= wb_fp_data;
            end

            age        <= age_next;
            pipe_stall <= !pipe_stall && (age_next == STALL_AGE);
            fp_busy    <= fp_busy_next;
        end
    end

endmodule
